// File: rtl/router_fsm_ctrl.sv
// Packet-sequencing FSM for the 1x3 router: decodes the header, waits on the
// destination FIFO and strobes the router register phases. Optional WAIT_TILL_EMPTY
// timeout is built only when ROUTER_FSM_TIMEOUT_EN is defined.
module router_fsm_ctrl #(
  parameter int WAIT_TIMEOUT = 256,
  parameter int CNT_W        = 16
) (
  input  logic       router_clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       full_state,
  output logic       laf_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_DECODE = 3'd0,
    S_LFD    = 3'd1,
    S_LD     = 3'd2,
    S_FULL   = 3'd3,
    S_LAF    = 3'd4,
    S_LP     = 3'd5,
    S_CHK    = 3'd6,
    S_WAIT   = 3'd7
  } state_t;

  if ((WAIT_TIMEOUT < 2) || (WAIT_TIMEOUT > 65535) ||
      ((CNT_W < 31) && (WAIT_TIMEOUT >= (1 << CNT_W)))) begin : g_bad_param
    $error("router_fsm_ctrl: illegal WAIT_TIMEOUT/CNT_W combination");
  end

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_addr;
  logic [1:0] w_addr;
  logic       w_empty_sel;
  logic       w_srst_sel;
  logic       w_hdr_ok;
  logic       w_timeout;

  // In DECODE the header on data_in selects the FIFO; afterwards the latched address does.
  always_comb begin
    w_addr      = (r_state == S_DECODE) ? data_in : r_addr;
    w_empty_sel = 1'b0;
    w_srst_sel  = 1'b0;
    case (w_addr)
      2'd0: begin w_empty_sel = fifo_empty_0; w_srst_sel = soft_reset_0; end
      2'd1: begin w_empty_sel = fifo_empty_1; w_srst_sel = soft_reset_1; end
      2'd2: begin w_empty_sel = fifo_empty_2; w_srst_sel = soft_reset_2; end
      default: begin w_empty_sel = 1'b0; w_srst_sel = 1'b0; end
    endcase
  end

  assign w_hdr_ok = pkt_valid && (data_in != 2'b11);

`ifdef ROUTER_FSM_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge router_clock) begin
    if (reset || (r_state != S_WAIT)) r_cnt <= '0;
    else                              r_cnt <= r_cnt + 1'b1;
  end

  assign w_timeout = (r_state == S_WAIT) && !w_empty_sel &&
                     (r_cnt == CNT_W'(WAIT_TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    if ((r_state != S_DECODE) && w_srst_sel) begin
      w_next = S_DECODE;
    end else begin
      case (r_state)
        S_DECODE: if (w_hdr_ok) w_next = w_empty_sel ? S_LFD : S_WAIT;
        S_LFD:    w_next = S_LD;
        S_LD:     if (fifo_full) w_next = S_FULL;
                  else if (!pkt_valid) w_next = S_LP;
        S_FULL:   if (!fifo_full) w_next = S_LAF;
        S_LAF:    if (parity_done) w_next = S_DECODE;
                  else if (low_pkt_valid) w_next = S_LP;
                  else w_next = S_LD;
        S_LP:     w_next = S_CHK;
        S_CHK:    w_next = fifo_full ? S_FULL : S_DECODE;
        S_WAIT:   if (w_empty_sel) w_next = S_LFD;
                  else if (w_timeout) w_next = S_DECODE;
        default:  w_next = S_DECODE;
      endcase
    end
  end

  // Outputs are registered from the next state so they always match r_state.
  always_ff @(posedge router_clock) begin
    if (reset) begin
      r_state       <= S_DECODE;
      r_addr        <= 2'b00;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      full_state    <= 1'b0;
      laf_state     <= 1'b0;
      rst_int_reg   <= 1'b0;
      write_enb_reg <= 1'b0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_DECODE) && w_hdr_ok) r_addr <= data_in;
      detect_add    <= (w_next == S_DECODE);
      lfd_state     <= (w_next == S_LFD);
      ld_state      <= (w_next == S_LD);
      full_state    <= (w_next == S_FULL);
      laf_state     <= (w_next == S_LAF);
      rst_int_reg   <= (w_next == S_CHK);
      write_enb_reg <= (w_next == S_LFD) || (w_next == S_LD) ||
                       (w_next == S_LP)  || (w_next == S_LAF);
      busy          <= !((w_next == S_DECODE) || (w_next == S_LD));
      timeout_err   <= w_timeout && !w_srst_sel;
    end
  end

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Bench for router_fsm_ctrl: directed packet scenarios followed by random cycles,
// every cycle compared against a phase-level reference model.
module tb_router_fsm_ctrl;

  localparam int T = 8;
`ifdef ROUTER_FSM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // Model phases (own numbering, unrelated to the design's encoding)
  localparam int M_DEC = 10, M_LFD = 11, M_LD = 12, M_FULL = 13,
                 M_LAF = 14, M_LP = 15, M_CHK = 16, M_WAIT = 17;

  logic clk = 1'b0;
  logic reset = 1'b1, pkt_valid = 1'b0, fifo_full = 1'b0;
  logic parity_done = 1'b0, low_pkt_valid = 1'b0;
  logic [1:0] data_in = 2'b00;
  logic [2:0] fe = 3'b111, sr = 3'b000;
  logic detect_add, lfd_state, ld_state, full_state, laf_state;
  logic rst_int_reg, write_enb_reg, busy, timeout_err;

  int tests = 0, fails = 0;
  int ms = M_DEC, ma = 0, mwait = 0;
  bit mto = 1'b0;
  string tag = "reset";
  logic [8:0] obs, exp;

  router_fsm_ctrl #(.WAIT_TIMEOUT(T), .CNT_W(16)) dut (
    .router_clock(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fe[0]), .fifo_empty_1(fe[1]),
    .fifo_empty_2(fe[2]), .soft_reset_0(sr[0]), .soft_reset_1(sr[1]),
    .soft_reset_2(sr[2]), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .full_state(full_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic model_next();
    int a, nxt;
    bit e, s;
    a = (ms == M_DEC) ? int'(data_in) : ma;
    e = (a == 3) ? 1'b0 : fe[a];
    s = (a == 3) ? 1'b0 : sr[a];
    mto = 1'b0;
    if (reset) begin
      ms = M_DEC; ma = 0; mwait = 0;
      return;
    end
    nxt = ms;
    if (ms == M_DEC && pkt_valid && data_in != 2'b11) ma = int'(data_in);
    if (ms != M_DEC && s) nxt = M_DEC;
    else if (ms == M_DEC) begin
      if (pkt_valid && data_in != 2'b11) nxt = e ? M_LFD : M_WAIT;
    end else if (ms == M_LFD) nxt = M_LD;
    else if (ms == M_LD) begin
      if (fifo_full) nxt = M_FULL; else if (!pkt_valid) nxt = M_LP;
    end else if (ms == M_FULL) begin
      if (!fifo_full) nxt = M_LAF;
    end else if (ms == M_LAF) begin
      nxt = parity_done ? M_DEC : (low_pkt_valid ? M_LP : M_LD);
    end else if (ms == M_LP) nxt = M_CHK;
    else if (ms == M_CHK) nxt = fifo_full ? M_FULL : M_DEC;
    else if (ms == M_WAIT) begin
      if (e) nxt = M_LFD;
      else if (TMO_EN && (mwait + 1 == T)) begin nxt = M_DEC; mto = 1'b1; end
    end
    mwait = (ms == M_WAIT && nxt == M_WAIT) ? mwait + 1 : 0;
    ms = nxt;
  endtask

  task automatic tick();
    model_next();
    @(posedge clk);
    #1;
    exp = {ms == M_DEC, ms == M_LFD, ms == M_LD, ms == M_FULL, ms == M_LAF,
           ms == M_CHK, (ms == M_LFD || ms == M_LD || ms == M_LP || ms == M_LAF),
           !(ms == M_DEC || ms == M_LD), mto};
    obs = {detect_add, lfd_state, ld_state, full_state, laf_state,
           rst_int_reg, write_enb_reg, busy, timeout_err};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s outputs obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s obs=%0d exp=%0d", name, got, want);
    end
  endtask

  initial begin
    int wen_cnt, rst_cnt, busy_cnt, full_cnt, to_cnt;
    // 1. reset for two cycles
    reset = 1'b1;
    tick(); tick();
    check_int("reset_outputs", int'(obs), int'(9'b100000000));
    reset = 1'b0;

    // 2. addr 1 packet, three payload bytes
    tag = "pkt_addr1";
    wen_cnt = 0; rst_cnt = 0;
    pkt_valid = 1'b1; data_in = 2'd1; fe = 3'b010;
    for (int i = 0; i < 4; i++) begin tick(); wen_cnt += int'(write_enb_reg); end
    pkt_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); wen_cnt += int'(write_enb_reg); rst_cnt += int'(rst_int_reg);
    end
    check_int("pkt_addr1_wen_cycles", wen_cnt, 5);
    check_int("pkt_addr1_rst_int_cycles", rst_cnt, 1);
    check_int("pkt_addr1_back_in_decode", int'(detect_add), 1);

    // 3. addr 2 with FIFO 2 busy for 10 cycles
    tag = "wait_empty";
    busy_cnt = 0;
    pkt_valid = 1'b1; data_in = 2'd2; fe = 3'b011;
    for (int i = 0; i < 10; i++) begin tick(); busy_cnt += int'(busy); end
    if (!TMO_EN) check_int("wait_busy_cycles", busy_cnt, 10);
    fe = 3'b111;
    tick();
    if (!TMO_EN) check_int("wait_then_lfd", int'(lfd_state), 1);

    // 4. FIFO full for four cycles mid-payload
    tag = "full_stall";
    full_cnt = 0;
    tick();
    fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); full_cnt += int'(full_state); end
    check_int("full_state_cycles", full_cnt, 4);
    fifo_full = 1'b0; parity_done = 1'b0; low_pkt_valid = 1'b0;
    tick();
    check_int("laf_after_full", int'(laf_state), 1);
    tick();
    check_int("laf_to_load_data", int'(ld_state), 1);
    pkt_valid = 1'b0;
    tick(); tick(); tick();

    // 5. address 3 header is dropped
    tag = "addr3_drop";
    pkt_valid = 1'b1; data_in = 2'b11;
    tick(); tick();
    check_int("addr3_not_busy", int'(busy), 0);

    // 6. soft reset of the addressed FIFO mid-payload
    tag = "soft_reset";
    data_in = 2'd0; fe = 3'b111;
    tick(); tick();
    sr = 3'b001;
    tick();
    check_int("srst_to_decode", int'(detect_add), 1);
    sr = 3'b000; pkt_valid = 1'b0;
    tick();

    if (TMO_EN) begin
      tag = "timeout";
      to_cnt = 0;
      pkt_valid = 1'b1; data_in = 2'd2; fe = 3'b011;
      for (int i = 0; i < T + 1; i++) begin tick(); to_cnt += int'(timeout_err); end
      check_int("timeout_pulse_seen", int'(timeout_err), 1);
      pkt_valid = 1'b0;
      tick(); to_cnt += int'(timeout_err);
      check_int("timeout_pulse_count", to_cnt, 1);
      fe = 3'b111;
      tick();
    end

    // Random traffic against the model
    tag = "random";
    for (int i = 0; i < 1500; i++) begin
      reset         = ($urandom_range(0, 63) == 0);
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = 2'($urandom_range(0, 3));
      fifo_full     = ($urandom_range(0, 3) == 0);
      fe            = 3'($urandom_range(0, 7));
      sr            = {($urandom_range(0, 31) == 0), ($urandom_range(0, 31) == 0),
                       ($urandom_range(0, 31) == 0)};
      parity_done   = ($urandom_range(0, 3) == 0);
      low_pkt_valid = $urandom_range(0, 1) == 1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
